// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that lets two bus masters share one system bus.
// Each grant carries one transfer, and a watchdog turns a missing s_rdy into an access fault.
module bus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_data_o,
   input  logic        m0_rd_n,
   input  logic        m0_wr_n,
   input  logic [3:0]  m0_lanes,
   output logic        m0_rdy,
   output logic        m0_acc_fault,
   output logic        m0_gnt,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_data_o,
   input  logic        m1_rd_n,
   input  logic        m1_wr_n,
   input  logic [3:0]  m1_lanes,
   output logic        m1_rdy,
   output logic        m1_acc_fault,
   output logic        m1_gnt,
   output logic [31:0] m_data_i,
   output logic [31:0] s_addr,
   output logic [31:0] s_data_o,
   output logic        s_rd_n,
   output logic        s_wr_n,
   output logic [3:0]  s_lanes,
   input  logic [31:0] s_data_i,
   input  logic        s_rdy,
   input  logic        s_acc_fault
);
   typedef enum logic [1:0] {IDLE, GNT0, GNT1, DONE} state_t;
   state_t          r_state, w_next;
   logic            r_last;
   logic [TO_W-1:0] r_wd;
   logic            w_req0, w_req1, w_g0, w_g1, w_gnt, w_req_g;
   logic            w_wd_fault, w_rdy, w_fault, w_end;
   assign w_req0     = ~m0_rd_n | ~m0_wr_n;
   assign w_req1     = ~m1_rd_n | ~m1_wr_n;
   assign w_g0       = r_state == GNT0;
   assign w_g1       = r_state == GNT1;
   assign w_gnt      = w_g0 | w_g1;
   assign w_req_g    = w_g0 ? w_req0 : w_req1;
   assign w_wd_fault = r_wd == TO_W'(TIMEOUT - 1);
   // A ready arriving on the expiry cycle wins; an aborting master gets neither strobe.
   assign w_rdy      = w_req_g & s_rdy;
   assign w_fault    = w_req_g & (s_acc_fault | (w_wd_fault & ~s_rdy));
   assign w_end      = ~w_req_g | s_rdy | s_acc_fault | w_wd_fault;
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = (w_req0 & (~w_req1 | r_last)) ? GNT0 : w_req1 ? GNT1 : IDLE;
      else if (r_state == DONE)
         w_next = IDLE;
      else if (w_end)
         w_next = DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_wd    <= '0;
      end else begin
         r_state <= w_next;
         if (w_gnt & w_end)
            r_last <= w_g1;
         r_wd <= (w_gnt & ~w_end) ? r_wd + 1'b1 : '0;
      end
   end
   assign m0_gnt       = w_g0;
   assign m1_gnt       = w_g1;
   assign m0_rdy       = w_g0 & w_rdy;
   assign m1_rdy       = w_g1 & w_rdy;
   assign m0_acc_fault = w_g0 & w_fault;
   assign m1_acc_fault = w_g1 & w_fault;
   assign m_data_i     = s_data_i;
   assign s_addr       = w_g0 ? m0_addr   : w_g1 ? m1_addr   : '0;
   assign s_data_o     = w_g0 ? m0_data_o : w_g1 ? m1_data_o : '0;
   assign s_lanes      = w_g0 ? m0_lanes  : w_g1 ? m1_lanes  : '0;
   assign s_rd_n       = w_g0 ? m0_rd_n   : w_g1 ? m1_rd_n   : 1'b1;
   assign s_wr_n       = w_g0 ? m0_wr_n   : w_g1 ? m1_wr_n   : 1'b1;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table with a scoreboard queue, plus an async reset sequence mid-grant.
module tb_bus_arbiter;
   localparam logic [31:0] A0 = 32'h1000_0000, D0 = 32'hAAAA_0001;
   localparam logic [31:0] A1 = 32'h2000_0040, D1 = 32'h5555_0002;
   localparam logic [3:0]  L0 = 4'b0011, L1 = 4'b1100;
   logic clk = 1'b0, rst = 1'b0;
   logic m0_rd_n = 1'b1, m0_wr_n = 1'b1, m1_rd_n = 1'b1, m1_wr_n = 1'b1;
   logic s_rdy = 1'b0, s_acc_fault = 1'b0;
   logic [31:0] s_data_i = '0;
   logic m0_rdy, m0_acc_fault, m0_gnt, m1_rdy, m1_acc_fault, m1_gnt, s_rd_n, s_wr_n;
   logic [31:0] m_data_i, s_addr, s_data_o;
   logic [3:0] s_lanes;
   int n_chk = 0, n_fail = 0;
   typedef struct {
      logic       rs;
      logic [5:0] in;
      logic [7:0] ex;
      logic [1:0] sel;
   } vec_t;
   typedef struct {
      logic [7:0]  ex;
      logic [1:0]  sel;
      logic [31:0] rd;
   } exp_t;
   vec_t tbl[$];
   exp_t exp_q[$];
   bus_arbiter #(.TIMEOUT(4), .TO_W(3)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(A0), .m0_data_o(D0), .m0_rd_n(m0_rd_n), .m0_wr_n(m0_wr_n), .m0_lanes(L0),
      .m0_rdy(m0_rdy), .m0_acc_fault(m0_acc_fault), .m0_gnt(m0_gnt),
      .m1_addr(A1), .m1_data_o(D1), .m1_rd_n(m1_rd_n), .m1_wr_n(m1_wr_n), .m1_lanes(L1),
      .m1_rdy(m1_rdy), .m1_acc_fault(m1_acc_fault), .m1_gnt(m1_gnt),
      .m_data_i(m_data_i), .s_addr(s_addr), .s_data_o(s_data_o), .s_rd_n(s_rd_n),
      .s_wr_n(s_wr_n), .s_lanes(s_lanes), .s_data_i(s_data_i), .s_rdy(s_rdy),
      .s_acc_fault(s_acc_fault)
   );
   always #5 clk = ~clk;
   function automatic vec_t v(logic rs, logic [5:0] in, logic [7:0] ex, logic [1:0] sel);
      vec_t t;
      t.rs = rs; t.in = in; t.ex = ex; t.sel = sel;
      return t;
   endfunction
   function automatic logic [7:0] flags();
      return {m0_gnt, m1_gnt, m0_rdy, m1_rdy, m0_acc_fault, m1_acc_fault, s_rd_n, s_wr_n};
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic drive(logic [5:0] in);
      m0_rd_n = ~in[5]; m0_wr_n = ~in[4]; m1_rd_n = ~in[3]; m1_wr_n = ~in[2];
      s_rdy = in[1]; s_acc_fault = in[0];
   endtask
   task automatic do_reset();
      @(negedge clk);
      drive(6'b0);
      rst = 1'b1;
      #1;
      chk("reset flags", {24'b0, flags()}, 32'h03);
      chk("reset s_addr", s_addr, 32'h0);
      chk("reset s_data_o", s_data_o, 32'h0);
      chk("reset s_lanes", {28'b0, s_lanes}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask
   initial begin
      exp_t e;
      // flags = {g0,g1,rdy0,rdy1,f0,f1,s_rd_n,s_wr_n}; in = {rd0,wr0,rd1,wr1,s_rdy,s_acc_fault}
      tbl.push_back(v(1, 6'b100000, 8'b00000011, 0));  // M0 read, ready on third grant cycle
      tbl.push_back(v(0, 6'b100000, 8'b10000001, 1));
      tbl.push_back(v(0, 6'b100000, 8'b10000001, 1));
      tbl.push_back(v(0, 6'b100010, 8'b10100001, 1));
      tbl.push_back(v(0, 6'b100000, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(1, 6'b100100, 8'b00000011, 0));  // simultaneous requests alternate
      tbl.push_back(v(0, 6'b100110, 8'b10100001, 1));
      tbl.push_back(v(0, 6'b100100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100110, 8'b01010010, 2));
      tbl.push_back(v(0, 6'b100100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100110, 8'b10100001, 1));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(1, 6'b000100, 8'b00000011, 0));  // M1 write, watchdog on 4th cycle
      tbl.push_back(v(0, 6'b000100, 8'b01000010, 2));
      tbl.push_back(v(0, 6'b000100, 8'b01000010, 2));
      tbl.push_back(v(0, 6'b000100, 8'b01000010, 2));
      tbl.push_back(v(0, 6'b000100, 8'b01000110, 2));
      tbl.push_back(v(0, 6'b000100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(1, 6'b100000, 8'b00000011, 0));  // ready on the expiry cycle
      tbl.push_back(v(0, 6'b100000, 8'b10000001, 1));
      tbl.push_back(v(0, 6'b100000, 8'b10000001, 1));
      tbl.push_back(v(0, 6'b100000, 8'b10000001, 1));
      tbl.push_back(v(0, 6'b100010, 8'b10100001, 1));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(1, 6'b000100, 8'b00000011, 0));  // slave fault on M1, then M0 wins tie
      tbl.push_back(v(0, 6'b000101, 8'b01000110, 2));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100100, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100110, 8'b10100001, 1));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100000, 8'b00000011, 0));  // M0 abort: no rdy even with s_rdy
      tbl.push_back(v(0, 6'b000010, 8'b10000011, 1));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b100000, 8'b00000011, 0));  // s_rdy with s_acc_fault both pass
      tbl.push_back(v(0, 6'b100011, 8'b10101001, 1));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      tbl.push_back(v(0, 6'b000000, 8'b00000011, 0));
      foreach (tbl[i]) begin
         if (tbl[i].rs) do_reset();
         @(negedge clk);
         drive(tbl[i].in);
         s_data_i = $urandom;
         exp_q.push_back('{tbl[i].ex, tbl[i].sel, s_data_i});
         #1;
         e = exp_q.pop_front();
         chk($sformatf("v%0d flags", i), {24'b0, flags()}, {24'b0, e.ex});
         chk($sformatf("v%0d s_addr", i), s_addr, e.sel == 1 ? A0 : e.sel == 2 ? A1 : 32'h0);
         chk($sformatf("v%0d s_data_o", i), s_data_o, e.sel == 1 ? D0 : e.sel == 2 ? D1 : 32'h0);
         chk($sformatf("v%0d s_lanes", i), {28'b0, s_lanes}, {28'b0, e.sel == 1 ? L0 : e.sel == 2 ? L1 : 4'b0});
         chk($sformatf("v%0d m_data_i", i), m_data_i, e.rd);
      end
      do_reset();
      @(negedge clk);
      drive(6'b100000);
      @(negedge clk);
      #1;
      chk("pre-rst m0_gnt", {31'b0, m0_gnt}, 32'h1);
      chk("pre-rst s_rd_n", {31'b0, s_rd_n}, 32'h0);
      #2 rst = 1'b1;
      #1;
      chk("async rst s_rd_n", {31'b0, s_rd_n}, 32'h1);
      chk("async rst m0_gnt", {31'b0, m0_gnt}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("regrant m0_gnt", {31'b0, m0_gnt}, 32'h1);
      chk("regrant s_addr", s_addr, A0);
      drive(6'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
